axi4_sram_slave: RTL and testbench
==================================

# axi4_sram_slave

AXI4 slave memory that sits directly downstream of the core's `io_master` port and serves both instruction fetches and LSU loads/stores in simulation and FPGA builds. It accepts single-beat and burst transactions (FIXED/INCR) on a 32-bit data bus, backs them with a synchronous single-port word array, and returns ID-tagged responses. Read and write share one array, so one transaction is serviced at a time under a fair AR/AW arbiter.

## Interface
- `ADDR_BASE`, 32'h8000_0000, byte address of word 0
- `DEPTH_WORDS`, 4096, array depth in 32-bit words (power of two)
- `clock`  input  1  single clock; all state changes on rising edge
- `reset`  input  1  synchronous, active-low (0 = reset)
- `awvalid`/`awready`  in/out  1/1  write address handshake
- `awaddr` in 32, `awid` in 4, `awlen` in 8, `awsize` in 3, `awburst` in 2  write address fields
- `wvalid`/`wready`  in/out  1/1  write data handshake
- `wdata` in 32, `wstrb` in 4, `wlast` in 1  write data; `wlast` ignored
- `bvalid`/`bready`  out/in  1/1  write response handshake
- `bresp` out 2, `bid` out 4  write response fields
- `arvalid`/`arready`  in/out  1/1  read address handshake
- `araddr` in 32, `arid` in 4, `arlen` in 8, `arsize` in 3, `arburst` in 2  read address fields
- `rvalid`/`rready`  out/in  1/1  read data handshake
- `rdata` out 32, `rresp` out 2, `rlast` out 1, `rid` out 4  read data fields

## Operation
- States: IDLE, RD, WR, WRESP. Registers: `addr`, `id`, `len`, `size`, `burst`, `beat` (8 b), `err` sticky, `last_wr` (last grant was write).
- IDLE: `arready = !awvalid | last_wr`; `awready = !arvalid | !last_wr`. Exactly one handshake per cycle. AR handshake → RD, `last_wr<=0`; AW handshake → WR, `last_wr<=1`.
- Address map: in range iff `ADDR_BASE <= a < ADDR_BASE + 4*DEPTH_WORDS`; word index = `(a-ADDR_BASE)>>2`.
- Next-beat address: FIXED (2'b00) holds; INCR (2'b01) and all other codes add `1<<size` (32-bit wrap); `size>2` treated as 2.
- RD: array read issued on handshake and on each accepted beat. `rvalid=1`, `rid=id`, `rlast=(beat==len)`. In range: `rdata`=word, `rresp=2'b00`; out of range: `rdata=0`, `rresp=2'b10`. On `rvalid&rready`: `beat++`, advance addr; if `rlast` → IDLE.
- WR: `wready=1`. On `wvalid&wready`: if in range, write byte lanes with `wstrb[i]=1` to the word; else discard and set `err`. `beat++`; when `beat==len` accepted → WRESP. Beat count comes only from `awlen`.
- WRESP: `bvalid=1`, `bid=id`, `bresp = err ? 2'b10 : 2'b00`; on `bready` → IDLE, clear `err`.

## Timing
- Reset (`reset==0` at edge): state IDLE, `last_wr=1` (read wins first tie); `rvalid`,`bvalid`,`wready`,`rlast`=0; `rdata`,`rresp`,`bresp`,`rid`,`bid`=0; `arready`/`awready` follow IDLE equations from first cycle after reset. Array contents untouched.
- Reset mid-transaction aborts immediately; no partial response emitted; beats already written stay written.
- Read latency: AR handshake at cycle N → `rvalid` at N+1. Back-to-back beats every cycle while `rready=1`.
- `rdata/rresp/rlast/rid` stable while `rvalid & !rready`.
- Write: AW at N → `wready` at N+1; last beat at M → `bvalid` at M+1; `bvalid` held until `bready`.
- After final R or B handshake at cycle K, IDLE at K+1; next address handshake earliest K+1.
- A write followed by a read of the same address returns the written data (no bypass needed: strictly serialised).
- `arvalid`/`awvalid` held by master across non-IDLE states are not accepted until IDLE.

## Test plan
- Single write `awaddr=8000_0010 awlen=0 awburst=0 awsize=0 wdata=DEADBEEF wstrb=F wlast=0`, then read same → `bresp=00`, `bid=awid`, `rdata=DEADBEEF`, `rlast=1`, `rvalid` one cycle after AR.
- INCR read burst `araddr=8000_0000 arlen=3 arsize=2` over words preloaded 1,2,3,4 with `rready` toggling → 1,2,3,4 in order, `rlast` only on 4th, data stable during stalls.
- Partial write `wstrb=4'b0101 wdata=AABBCCDD` over `11223344` → readback `11BB33DD`.
- Out-of-range read `araddr=0000_0000` → `rdata=0 rresp=10`; write burst `awlen=1` crossing top of array → first beat stored, `bresp=10`.
- `arvalid` and `awvalid` asserted same cycle twice in a row → read granted first, write second; then alternate.
- Reset asserted during beat 2 of a 4-beat read → `rvalid=0` next cycle, IDLE, subsequent read correct.

Source files
------------

// File: rtl/axi4_sram_slave_if.sv
// AXI4 address/data/response channels between a master and the SRAM slave.
// Clock and reset stay outside the bundle as plain ports.
interface axi4_sram_slave_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave over a single-port word SRAM, one transaction at a time, fair AR/AW arbitration.
// Latency: AR -> first R one cycle; AW -> wready one cycle; last W -> B one cycle.
// Backpressure: R/B held stable until rready/bready; address channels stall outside IDLE.
module axi4_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input logic              clock,
    input logic              reset,
    axi4_sram_slave_if.slave axi
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t      state;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  beat;
    logic        err;
    logic        last_wr;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mem_q;

    logic        ar_hs, aw_hs, r_hs, w_hs;
    logic        mem_re, mem_we;
    logic [31:0] nxt_addr, rd_addr;
    logic        unused_wlast;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= ADDR_BASE) && (33'(a - ADDR_BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    // Sizes above a word are clamped to a word; any non-FIXED burst increments.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] bt);
        logic [1:0] s;
        s = (sz > 3'd2) ? 2'd2 : sz[1:0];
        return (bt == 2'b00) ? a : a + (32'd1 << s);
    endfunction

    // Ties go to whichever channel was not granted last.
    assign axi.arready = (state == IDLE) && (!axi.awvalid || last_wr);
    assign axi.awready = (state == IDLE) && (!axi.arvalid || !last_wr);

    assign ar_hs    = axi.arvalid && axi.arready;
    assign aw_hs    = axi.awvalid && axi.awready;
    assign r_hs     = (state == RD) && axi.rvalid && axi.rready;
    assign w_hs     = (state == WR) && axi.wvalid && axi.wready;
    assign nxt_addr = next_addr(addr, size, burst);

    assign mem_re  = ar_hs || (r_hs && !axi.rlast);
    assign rd_addr = ar_hs ? axi.araddr : nxt_addr;
    assign mem_we  = reset && w_hs && in_range(addr);

    assign unused_wlast = axi.wlast;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (axi.wstrb[i]) mem[word_idx(addr)][8*i +: 8] <= axi.wdata[8*i +: 8];
            end
        end
        if (mem_re) mem_q <= mem[word_idx(rd_addr)];
    end

    // mem_q is only meaningful while an in-range beat is presented.
    assign axi.rdata = (axi.rvalid && axi.rresp == 2'b00) ? mem_q : 32'd0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_wr    <= 1'b1;
            err        <= 1'b0;
            addr       <= '0;
            id         <= '0;
            len        <= '0;
            size       <= '0;
            burst      <= '0;
            beat       <= '0;
            axi.rvalid <= 1'b0;
            axi.rlast  <= 1'b0;
            axi.rresp  <= 2'b00;
            axi.rid    <= '0;
            axi.wready <= 1'b0;
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'b00;
            axi.bid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        state      <= RD;
                        last_wr    <= 1'b0;
                        addr       <= axi.araddr;
                        id         <= axi.arid;
                        len        <= axi.arlen;
                        size       <= axi.arsize;
                        burst      <= axi.arburst;
                        beat       <= '0;
                        axi.rvalid <= 1'b1;
                        axi.rid    <= axi.arid;
                        axi.rlast  <= (axi.arlen == 8'd0);
                        axi.rresp  <= in_range(axi.araddr) ? 2'b00 : 2'b10;
                    end else if (aw_hs) begin
                        state      <= WR;
                        last_wr    <= 1'b1;
                        addr       <= axi.awaddr;
                        id         <= axi.awid;
                        len        <= axi.awlen;
                        size       <= axi.awsize;
                        burst      <= axi.awburst;
                        beat       <= '0;
                        axi.wready <= 1'b1;
                    end
                end
                RD: begin
                    if (r_hs) begin
                        if (axi.rlast) begin
                            state      <= IDLE;
                            axi.rvalid <= 1'b0;
                            axi.rlast  <= 1'b0;
                        end else begin
                            addr      <= nxt_addr;
                            beat      <= beat + 8'd1;
                            axi.rlast <= ((beat + 8'd1) == len);
                            axi.rresp <= in_range(nxt_addr) ? 2'b00 : 2'b10;
                        end
                    end
                end
                WR: begin
                    if (w_hs) begin
                        addr <= nxt_addr;
                        beat <= beat + 8'd1;
                        if (!in_range(addr)) err <= 1'b1;
                        if (beat == len) begin
                            state      <= WRESP;
                            axi.wready <= 1'b0;
                            axi.bvalid <= 1'b1;
                            axi.bid    <= id;
                            axi.bresp  <= (err || !in_range(addr)) ? 2'b10 : 2'b00;
                        end
                    end
                end
                WRESP: begin
                    if (axi.bready) begin
                        state      <= IDLE;
                        axi.bvalid <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: writes, bursts, strobes, range errors, arbitration, reset abort.
module tb_axi4_sram_slave;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    axi4_sram_slave_if axi ();

    axi4_sram_slave #(
        .ADDR_BASE  (32'h8000_0000),
        .DEPTH_WORDS(4096)
    ) dut (
        .clock(clock),
        .reset(reset),
        .axi  (axi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.awvalid = 1'b1; axi.awaddr = a; axi.awid = id;
        axi.awlen = len; axi.awsize = size; axi.awburst = burst;
        #1;
        while (!axi.awready && n < 50) begin tick(); n++; end
        chkb("aw_ready", axi.awready, 1'b1);
        tick();
        axi.awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi.arvalid = 1'b1; axi.araddr = a; axi.arid = id;
        axi.arlen = len; axi.arsize = size; axi.arburst = burst;
        #1;
        while (!axi.arready && n < 50) begin tick(); n++; end
        chkb("ar_ready", axi.arready, 1'b1);
        tick();
        axi.arvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] strb);
        int n = 0;
        axi.wvalid = 1'b1; axi.wdata = d; axi.wstrb = strb; axi.wlast = 1'b0;
        #1;
        while (!axi.wready && n < 50) begin tick(); n++; end
        chkb("w_ready", axi.wready, 1'b1);
        tick();
        axi.wvalid = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [1:0] resp, input logic [3:0] id);
        int n = 0;
        axi.bready = 1'b1;
        #1;
        while (!axi.bvalid && n < 50) begin tick(); n++; end
        chkb({tag, "_bvalid"}, axi.bvalid, 1'b1);
        chk({tag, "_bresp"}, 32'(axi.bresp), 32'(resp));
        chk({tag, "_bid"}, 32'(axi.bid), 32'(id));
        tick();
        axi.bready = 1'b0;
    endtask

    task automatic do_r(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
        int n = 0;
        axi.rready = 1'b1;
        #1;
        while (!axi.rvalid && n < 50) begin tick(); n++; end
        chkb({tag, "_rvalid"}, axi.rvalid, 1'b1);
        chk({tag, "_rdata"}, axi.rdata, d);
        chk({tag, "_rresp"}, 32'(axi.rresp), 32'(resp));
        chkb({tag, "_rlast"}, axi.rlast, last);
        chk({tag, "_rid"}, 32'(axi.rid), 32'(id));
        tick();
        axi.rready = 1'b0;
    endtask

    logic [31:0] burst_words [4];

    initial begin
        checks = 0;
        errors = 0;
        burst_words[0] = 32'd1; burst_words[1] = 32'd2;
        burst_words[2] = 32'd3; burst_words[3] = 32'd4;

        axi.awvalid = 0; axi.awaddr = 0; axi.awid = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.araddr = 0; axi.arid = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.rready = 0;

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        chkb("rst_rvalid", axi.rvalid, 1'b0);
        chkb("rst_bvalid", axi.bvalid, 1'b0);
        chkb("rst_wready", axi.wready, 1'b0);
        chkb("rst_rlast", axi.rlast, 1'b0);
        chk("rst_rdata", axi.rdata, 32'd0);
        chk("rst_rresp", 32'(axi.rresp), 32'd0);
        chk("rst_bresp", 32'(axi.bresp), 32'd0);
        chk("rst_rid", 32'(axi.rid), 32'd0);
        chk("rst_bid", 32'(axi.bid), 32'd0);
        reset = 1'b1;
        tick();
        chkb("idle_arready", axi.arready, 1'b1);
        chkb("idle_awready", axi.awready, 1'b1);

        // Single write then read back, with latency checks
        do_aw(32'h8000_0010, 4'hA, 8'd0, 3'd0, 2'b00);
        chkb("wr_lat_wready", axi.wready, 1'b1);
        do_w(32'hDEAD_BEEF, 4'hF);
        chkb("wr_lat_bvalid", axi.bvalid, 1'b1);
        do_b("single_wr", 2'b00, 4'hA);
        do_ar(32'h8000_0010, 4'h1, 8'd0, 3'd2, 2'b01);
        chkb("rd_lat_rvalid", axi.rvalid, 1'b1);
        do_r("single_rd", 32'hDEAD_BEEF, 2'b00, 1'b1, 4'h1);
        chkb("rd_done_rvalid", axi.rvalid, 1'b0);
        chkb("rd_done_arready", axi.arready, 1'b1);

        // INCR burst preload then burst read with rready stalls
        do_aw(32'h8000_0000, 4'h2, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) do_w(burst_words[i], 4'hF);
        do_b("burst_wr", 2'b00, 4'h2);
        do_ar(32'h8000_0000, 4'h3, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk("burst_stall_rdata_a", axi.rdata, burst_words[i]);
            tick();
            chkb("burst_stall_rvalid", axi.rvalid, 1'b1);
            chk("burst_stall_rdata_b", axi.rdata, burst_words[i]);
            chkb("burst_stall_rlast", axi.rlast, (i == 3));
            axi.rready = 1'b1;
            tick();
            axi.rready = 1'b0;
        end
        chkb("burst_end_rvalid", axi.rvalid, 1'b0);

        // Partial write with byte strobes
        do_aw(32'h8000_0020, 4'h4, 8'd0, 3'd2, 2'b01);
        do_w(32'h1122_3344, 4'hF);
        do_b("base_wr", 2'b00, 4'h4);
        do_aw(32'h8000_0020, 4'h4, 8'd0, 3'd2, 2'b01);
        do_w(32'hAABB_CCDD, 4'b0101);
        do_b("strb_wr", 2'b00, 4'h4);
        do_ar(32'h8000_0020, 4'h4, 8'd0, 3'd2, 2'b01);
        do_r("strb_rd", 32'h11BB_33DD, 2'b00, 1'b1, 4'h4);

        // Out of range read, and a write burst running off the top of the array
        do_ar(32'h0000_0000, 4'h7, 8'd0, 3'd2, 2'b01);
        do_r("oor_rd", 32'd0, 2'b10, 1'b1, 4'h7);
        do_aw(32'h8000_3FFC, 4'h2, 8'd1, 3'd2, 2'b01);
        do_w(32'hCAFE_F00D, 4'hF);
        do_w(32'h1234_5678, 4'hF);
        do_b("top_wr", 2'b10, 4'h2);
        do_ar(32'h8000_3FFC, 4'h2, 8'd0, 3'd2, 2'b01);
        do_r("top_rd", 32'hCAFE_F00D, 2'b00, 1'b1, 4'h2);
        do_aw(32'h8000_0044, 4'h8, 8'd0, 3'd2, 2'b01);
        do_w(32'h0000_0077, 4'hF);
        do_b("err_cleared", 2'b00, 4'h8);

        // Arbitration: last grant was a write, so a tie goes to the read
        axi.arvalid = 1'b1; axi.araddr = 32'h8000_0000; axi.arid = 4'h3;
        axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01;
        axi.awvalid = 1'b1; axi.awaddr = 32'h8000_0040; axi.awid = 4'h5;
        axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01;
        #1;
        chkb("tie1_arready", axi.arready, 1'b1);
        chkb("tie1_awready", axi.awready, 1'b0);
        tick();
        axi.araddr = 32'h8000_0004;
        chkb("tie1_rvalid", axi.rvalid, 1'b1);
        chkb("tie1_aw_held", axi.awready, 1'b0);
        do_r("tie1_rd", 32'd1, 2'b00, 1'b1, 4'h3);
        #1;
        chkb("tie2_awready", axi.awready, 1'b1);
        chkb("tie2_arready", axi.arready, 1'b0);
        tick();
        axi.awvalid = 1'b0;
        do_w(32'h0000_0066, 4'hF);
        do_b("tie2_wr", 2'b00, 4'h5);
        axi.awvalid = 1'b1; axi.awaddr = 32'h8000_0048; axi.awid = 4'h6;
        #1;
        chkb("tie3_arready", axi.arready, 1'b1);
        chkb("tie3_awready", axi.awready, 1'b0);
        tick();
        axi.arvalid = 1'b0;
        do_r("tie3_rd", 32'd2, 2'b00, 1'b1, 4'h3);
        #1;
        chkb("tie4_awready", axi.awready, 1'b1);
        tick();
        axi.awvalid = 1'b0;
        do_w(32'h0000_0099, 4'hF);
        do_b("tie4_wr", 2'b00, 4'h6);
        do_ar(32'h8000_0040, 4'h9, 8'd1, 3'd2, 2'b01);
        do_r("tie_rb0", 32'h0000_0066, 2'b00, 1'b0, 4'h9);
        do_r("tie_rb1", 32'h0000_0077, 2'b00, 1'b1, 4'h9);
        do_ar(32'h8000_0048, 4'h9, 8'd0, 3'd2, 2'b01);
        do_r("tie_rb2", 32'h0000_0099, 2'b00, 1'b1, 4'h9);

        // Reset during the third beat of a 4-beat read
        do_ar(32'h8000_0000, 4'hB, 8'd3, 3'd2, 2'b01);
        do_r("abort_b0", 32'd1, 2'b00, 1'b0, 4'hB);
        do_r("abort_b1", 32'd2, 2'b00, 1'b0, 4'hB);
        reset = 1'b0;
        tick();
        chkb("abort_rvalid", axi.rvalid, 1'b0);
        chkb("abort_idle", axi.arready, 1'b1);
        reset = 1'b1;
        tick();
        do_ar(32'h8000_0008, 4'hC, 8'd0, 3'd2, 2'b01);
        do_r("post_abort_rd", 32'd3, 2'b00, 1'b1, 4'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
